i2c_slv_l2_writer: RTL and testbench

Packs the byte stream received by the PMS I2C slave peripheral into 32-bit little-endian words and writes them into L2 through a req/gnt memory port. Addresses auto-increment from a programmable base. Each I2C write transaction, from START to STOP, becomes one contiguous burst of word writes, ending with a byte-enabled partial word if needed. The block sits between the I2C slave bus-protocol engine, which supplies bytes and START/STOP events, and the L2 interconnect.

---
 rtl/i2c_slv_l2_writer.sv | 188 ++++++++++++++++++
 tb/tb_i2c_slv_l2_writer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slv_l2_writer.sv
// Packs I2C slave receive bytes into 32-bit little-endian words and writes them to L2 over a req/gnt port.
// Optional running byte checksum on chksum_o when I2C_SLV_L2_WRITER_CHKSUM_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for an enabled START, nothing pending
// S_ACTIVE | accepting bytes, packing words, issuing full-word writes
// S_DRAIN  | STOP seen: flush the partial word, wait for the write buffer
module i2c_slv_l2_writer #(
  parameter int MAX_WORDS  = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           word_cnt_o,
  output logic                  overflow_o,
  output logic [7:0]            chksum_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_asm;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_wb_data;
  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [3:0]            r_wb_be;
  logic                  r_wb_valid;
  logic [15:0]           r_word_cnt;
  logic                  r_overflow;

  logic                  w_rx_ready;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_done;
  logic [31:0]           w_asm_acc;
  logic [1:0]            w_idx_acc;
  logic                  w_full;
  logic                  w_flushing;
  logic                  w_partial;
  logic                  w_push;
  logic                  w_room;
  logic [3:0]            w_push_be;

  assign w_rx_ready = (r_state == S_ACTIVE) && !((r_byte_idx == 2'd3) && r_wb_valid);
  assign w_accept   = rx_valid_i && w_rx_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && enable_i && !stop_i) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (stop_i) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_byte_idx == 2'd0) && !r_wb_valid) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_start = (r_state == S_IDLE) && (w_state_nxt == S_ACTIVE);

  always_comb begin
    w_asm_acc = r_asm;
    if (w_accept) w_asm_acc[{r_byte_idx, 3'b000} +: 8] = rx_data_i;
  end

  assign w_idx_acc = w_accept ? (r_byte_idx + 2'd1) : r_byte_idx;
  assign w_full    = w_accept && (r_byte_idx == 2'd3);

  // The partial word may leave in the STOP cycle itself, so a byte arriving with STOP is included.
  assign w_flushing = ((r_state == S_ACTIVE) && stop_i) || (r_state == S_DRAIN);
  assign w_partial  = w_flushing && !w_full && (w_idx_acc != 2'd0) && !r_wb_valid;
  assign w_push     = w_full || w_partial;
  assign w_room     = {16'd0, r_word_cnt} < 32'(MAX_WORDS);

  always_comb begin
    w_push_be = 4'b1111;
    if (!w_full) begin
      case (w_idx_acc)
        2'd1:    w_push_be = 4'b0001;
        2'd2:    w_push_be = 4'b0011;
        2'd3:    w_push_be = 4'b0111;
        default: w_push_be = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_asm      <= '0;
      r_byte_idx <= 2'd0;
      r_wb_data  <= '0;
      r_wb_addr  <= '0;
      r_wb_be    <= 4'd0;
      r_wb_valid <= 1'b0;
      r_word_cnt <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_wb_valid && mem_gnt_i) r_wb_valid <= 1'b0;
      if (w_start) begin
        r_addr     <= base_addr_i & ~ADDR_WIDTH'(3);
        r_asm      <= '0;
        r_byte_idx <= 2'd0;
        r_word_cnt <= 16'd0;
        r_overflow <= 1'b0;
      end else if (w_push) begin
        // A push only happens with the buffer free, so the load cannot collide with a grant.
        r_asm      <= '0;
        r_byte_idx <= 2'd0;
        if (w_room) begin
          r_wb_valid <= 1'b1;
          r_wb_data  <= w_asm_acc;
          r_wb_addr  <= r_addr;
          r_wb_be    <= w_push_be;
          r_addr     <= r_addr + ADDR_WIDTH'(4);
          if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else begin
        r_asm      <= w_asm_acc;
        r_byte_idx <= w_idx_acc;
      end
    end
  end

`ifdef I2C_SLV_L2_WRITER_CHKSUM_EN
  logic [7:0] r_chksum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_chksum <= 8'h00;
    end else if (w_start) begin
      r_chksum <= 8'h00;
    end else if (w_accept) begin
      r_chksum <= r_chksum + rx_data_i;
    end
  end

  assign chksum_o = r_chksum;
`else
  assign chksum_o = 8'h00;
`endif

  assign rx_ready_o  = w_rx_ready;
  assign mem_req_o   = r_wb_valid;
  assign mem_we_o    = r_wb_valid;
  assign mem_addr_o  = r_wb_addr;
  assign mem_wdata_o = r_wb_data;
  assign mem_be_o    = r_wb_be;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = w_done;
  assign word_cnt_o  = r_word_cnt;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_i2c_slv_l2_writer.sv
// Bench for i2c_slv_l2_writer: transaction-level write model plus per-cycle protocol checks.
module tb_i2c_slv_l2_writer;
  localparam int MAXW = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        mem_gnt_i = 1'b1;
  logic        rx_ready_o, mem_req_o, mem_we_o, busy_o, done_o, overflow_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [15:0] word_cnt_o;
  logic [7:0]  chksum_o;

  i2c_slv_l2_writer #(.MAX_WORDS(MAXW), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .base_addr_i(base_addr_i),
    .start_i(start_i), .stop_i(stop_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rx_ready_o(rx_ready_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .busy_o(busy_o),
    .done_o(done_o), .word_cnt_o(word_cnt_o), .overflow_o(overflow_o), .chksum_o(chksum_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  int   total = 0;
  int   bad = 0;
  wr_t  exp_q[$];
  wr_t  log_q[$];
  int   m_phase = 0;
  int   m_nb = 0;
  bit   exp_req_nxt = 0;
  bit   exp_done_nxt = 0;
  bit   stall_prev = 0;
  logic [31:0] s_a, s_d;
  logic [3:0]  s_be;
  int   n_done = 0;
  int   g_mode = 0;
  int   g_low = 0;
  logic [7:0] tx_bytes[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (log_q.size() > i) begin
      chk($sformatf("log%0d_addr", i), log_q[i].a, a);
      chk($sformatf("log%0d_data", i), log_q[i].d, d);
      chk($sformatf("log%0d_be", i), 32'(log_q[i].be), 32'(be));
    end else begin
      total++;
      bad++;
      $display("FAIL log%0d_missing: writes seen %0d required more than %0d", i, log_q.size(), i);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready_o), 0);
    chk({tag, "_req"}, 32'(mem_req_o), 0);
    chk({tag, "_we"}, 32'(mem_we_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_ovf"}, 32'(overflow_o), 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_be"}, 32'(mem_be_o), 0);
    chk({tag, "_cnt"}, 32'(word_cnt_o), 0);
    chk({tag, "_chksum"}, 32'(chksum_o), 0);
  endtask

  // Grant generator: optional forced-low window, then always-high or random.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (g_low > 0) begin
        mem_gnt_i = 1'b0;
        g_low--;
      end else begin
        mem_gnt_i = (g_mode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Per-cycle compare process: judges the cycle, then advances the model to the next edge.
  always begin
    bit  acc, nxt_req, nxt_done;
    int  nb_after;
    wr_t e;
    @(negedge clk_i);
    #2;
    if (rst_i) begin
      m_phase = 0; m_nb = 0; exp_req_nxt = 0; exp_done_nxt = 0; stall_prev = 0;
      exp_q.delete();
    end else begin
      chk("we_eq_req", 32'(mem_we_o), 32'(mem_req_o));
      chk("busy", 32'(busy_o), 32'(m_phase != 0));
      chk("rx_ready", 32'(rx_ready_o), 32'((m_phase == 1) && !((m_nb % 4 == 3) && mem_req_o)));
      if (exp_req_nxt) chk("req_latency", 32'(mem_req_o), 1);
      if (exp_done_nxt) chk("done_latency", 32'(done_o), 1);
      if (stall_prev) begin
        chk("hold_req", 32'(mem_req_o), 1);
        chk("hold_addr", mem_addr_o, s_a);
        chk("hold_wdata", mem_wdata_o, s_d);
        chk("hold_be", 32'(mem_be_o), 32'(s_be));
      end
      if (done_o) begin
        chk("done_phase", m_phase, 2);
        chk("done_drained", exp_q.size(), 0);
        n_done++;
      end
      nxt_req = 0;
      nxt_done = 0;
      if (mem_req_o && mem_gnt_i) begin
        e.a = mem_addr_o; e.d = mem_wdata_o; e.be = mem_be_o;
        log_q.push_back(e);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL write_unexpected: got addr %h data %h be %b required none", mem_addr_o, mem_wdata_o, mem_be_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr_o, e.a);
          chk("wr_data", mem_wdata_o, e.d);
          chk("wr_be", 32'(mem_be_o), 32'(e.be));
          if (m_phase == 2 && exp_q.size() == 0 && ((m_nb % 4 == 0) || e.be != 4'hF)) nxt_done = 1;
        end
      end
      stall_prev = mem_req_o && !mem_gnt_i;
      s_a = mem_addr_o; s_d = mem_wdata_o; s_be = mem_be_o;
      acc = rx_valid_i && rx_ready_o;
      case (m_phase)
        0: if (start_i && enable_i && !stop_i) begin m_phase = 1; m_nb = 0; end
        1: begin
          nb_after = m_nb + int'(acc);
          if (acc && nb_after % 4 == 0 && nb_after / 4 <= MAXW) nxt_req = 1;
          if (stop_i) begin
            m_phase = 2;
            if (!mem_req_o && nb_after % 4 != 0 && (nb_after + 3) / 4 <= MAXW) nxt_req = 1;
            if (!mem_req_o && !nxt_req && nb_after % 4 == 0) nxt_done = 1;
          end
          m_nb = nb_after;
        end
        default: if (done_o) m_phase = 0;
      endcase
      exp_req_nxt = nxt_req;
      exp_done_nxt = nxt_done;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit with_stop);
    int k;
    rx_valid_i = 1'b1;
    rx_data_i = b;
    k = 0;
    @(negedge clk_i);
    #1;
    while (!rx_ready_o && k < 300) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    if (!rx_ready_o) begin
      total++;
      bad++;
      $display("FAIL byte_accept_timeout: ready %b required 1", rx_ready_o);
    end
    if (with_stop) stop_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    stop_i = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] base, input int n, input bit gaps, input bit stop_last,
                         input bit restart, input bit start_stop);
    int d0, groups, c;
    logic [31:0] abase;
    logic [7:0] sum;
    wr_t w;
    abase = base & 32'hFFFF_FFFC;
    groups = (n + 3) / 4;
    sum = 8'h00;
    for (int g = 0; g < groups && g < MAXW; g++) begin
      w.a = abase + 32'(4 * g);
      w.d = '0;
      w.be = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * g + k < n) begin
          w.d[8*k +: 8] = tx_bytes[4*g+k];
          w.be[k] = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
    for (int i = 0; i < n; i++) sum = sum + tx_bytes[i];
    d0 = n_done;
    @(posedge clk_i);
    #1;
    base_addr_i = base; enable_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("start_clr_cnt", 32'(word_cnt_o), 0);
    chk("start_clr_ovf", 32'(overflow_o), 0);
    chk("start_clr_chksum", 32'(chksum_o), 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        c = $urandom_range(0, 2);
        repeat (c) begin @(posedge clk_i); #1; end
      end
      if (restart && i == n / 2) begin
        base_addr_i = ~base; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
      end
      send_byte(tx_bytes[i], stop_last && i == n - 1);
    end
    if (!(stop_last && n > 0)) begin
      stop_i = 1'b1; start_i = start_stop;
      @(posedge clk_i);
      #1;
      stop_i = 1'b0; start_i = 1'b0;
    end
    c = 0;
    while (n_done == d0 && c < 300) begin
      @(posedge clk_i);
      #1;
      c++;
    end
    chk("done_count", n_done - d0, 1);
    chk("end_busy", 32'(busy_o), 0);
    chk("end_cnt", 32'(word_cnt_o), (groups < MAXW) ? groups : MAXW);
    chk("end_ovf", 32'(overflow_o), 32'(groups > MAXW));
`ifdef I2C_SLV_L2_WRITER_CHKSUM_EN
    chk("end_chksum", 32'(chksum_o), 32'(sum));
`else
    chk("end_chksum", 32'(chksum_o), 0);
`endif
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero("reset");
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    g_mode = 0;
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h11 + 8'(i);
    log_q.delete();
    run_txn(32'h1C01_0000, 8, 0, 0, 0, 0);
    chk_log(0, 32'h1C01_0000, 32'h1413_1211, 4'b1111);
    chk_log(1, 32'h1C01_0004, 32'h1817_1615, 4'b1111);
    chk("t1_cnt", 32'(word_cnt_o), 2);
`ifdef I2C_SLV_L2_WRITER_CHKSUM_EN
    chk("t1_chksum", 32'(chksum_o), 32'hA4);
`endif

    tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB; tx_bytes[2] = 8'hCC;
    log_q.delete();
    run_txn(32'h1C01_0000, 3, 0, 0, 0, 0);
    chk_log(0, 32'h1C01_0000, 32'h00CC_BBAA, 4'b0111);
    chk("t2_cnt", 32'(word_cnt_o), 1);

    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h21 + 8'(i);
    g_low = 22;
    fork
      run_txn(32'h1C02_0000, 8, 0, 0, 0, 0);
      begin
        repeat (15) @(posedge clk_i);
        #1;
        chk("stall_accepted", m_nb, 7);
        chk("stall_ready", 32'(rx_ready_o), 0);
        chk("stall_wdata", mem_wdata_o, 32'h2423_2221);
      end
    join

    for (int i = 0; i < 12; i++) tx_bytes[i] = 8'(i * 7 + 3);
    log_q.delete();
    run_txn(32'h1C03_0000, 12, 0, 0, 0, 0);
    chk("ovf_sticky", 32'(overflow_o), 1);
    chk("ovf_writes", log_q.size(), 2);

    for (int i = 0; i < 6; i++) tx_bytes[i] = 8'h51 + 8'(i);
    log_q.delete();
    run_txn(32'hFFFF_FFFE, 6, 0, 1, 0, 0);
    chk_log(0, 32'hFFFF_FFFC, 32'h5453_5251, 4'b1111);
    chk_log(1, 32'h0000_0000, 32'h0000_5655, 4'b0011);

    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom);
    log_q.delete();
    run_txn(32'h1C04_0000, 8, 0, 0, 1, 0);
    chk_log(1, 32'h1C04_0004, {tx_bytes[7], tx_bytes[6], tx_bytes[5], tx_bytes[4]}, 4'b1111);
    run_txn(32'h1C05_0000, 5, 1, 0, 0, 1);

    @(posedge clk_i);
    #1;
    enable_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
      chk("disabled_busy", 32'(busy_o), 0);
    end
    stop_i = 1'b1;
    @(posedge clk_i);
    #1;
    stop_i = 1'b0;
    chk("idle_stop_busy", 32'(busy_o), 0);
    chk("idle_stop_done", 32'(done_o), 0);

    g_low = 1000;
    @(posedge clk_i);
    #1;
    base_addr_i = 32'h2000_0000; enable_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    @(posedge clk_i);
    #1;
    chk("rst_req_pending", 32'(mem_req_o), 1);
    rst_i = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    g_low = 0;
    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'hC0 + 8'(i);
    log_q.delete();
    run_txn(32'h3000_0010, 4, 0, 0, 0, 0);
    chk_log(0, 32'h3000_0010, 32'hC3C2_C1C0, 4'b1111);

    g_mode = 1;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 13);
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
      run_txn($urandom, n, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
